// File: rtl/router_port_rx.sv
// Receive side of one router input port: serial frame parser, hold register
// and first-word-fall-through payload FIFO with busy_n back-pressure.
module router_port_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int PAD_CYCLES  = 5,
  parameter int BUSY_THRESH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       frame_n,
  input  logic       valid_n,
  output logic       busy_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_addr,
  output logic       out_last,
  output logic       err_frame,
  output logic       err_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAD_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;

  logic [2:0]       state;
  logic [1:0]       addr_cnt;
  logic [2:0]       addr_sr;
  logic [3:0]       pkt_addr;
  logic [PAD_W-1:0] pad_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       shift;
  logic [7:0]       hold_data;
  logic             hold_vld;

  logic             push_req;
  logic             push_last;
  logic             byte_done;
  logic [12:0]      push_entry;

  logic [12:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             push;
  logic             pop;

  // A byte is only pushed once its successor completes (or the frame ends),
  // so the final byte of every packet can be tagged last in FLUSH.
  always_comb begin
    byte_done  = (state == S_PAYLOAD) && !valid_n && (bit_cnt == 3'd7);
    push_req   = 1'b0;
    push_last  = 1'b0;
    if (byte_done && hold_vld) push_req = 1'b1;
    if (state == S_FLUSH) begin
      push_req  = 1'b1;
      push_last = 1'b1;
    end
    push_entry = {pkt_addr, push_last, hold_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_vld  <= 1'b0;
      err_frame <= 1'b0;
      addr_cnt  <= 2'd0;
      pad_cnt   <= '0;
      bit_cnt   <= 3'd0;
    end else begin
      err_frame <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!frame_n) begin
            addr_sr  <= {din, addr_sr[2:1]};
            addr_cnt <= 2'd1;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (frame_n) begin
            err_frame <= 1'b1;
            state     <= S_IDLE;
          end else if (addr_cnt == 2'd3) begin
            pkt_addr <= {din, addr_sr};
            pad_cnt  <= '0;
            state    <= S_PAD;
          end else begin
            addr_sr  <= {din, addr_sr[2:1]};
            addr_cnt <= addr_cnt + 2'd1;
          end
        end
        S_PAD: begin
          if (frame_n) begin
            err_frame <= 1'b1;
            state     <= S_IDLE;
          end else if (pad_cnt == PAD_W'(PAD_CYCLES - 1)) begin
            bit_cnt <= 3'd0;
            state   <= S_PAYLOAD;
          end else begin
            pad_cnt <= pad_cnt + PAD_W'(1);
          end
        end
        S_PAYLOAD: begin
          if (byte_done) begin
            hold_data <= {din, shift};
            hold_vld  <= 1'b1;
            bit_cnt   <= 3'd0;
            if (frame_n) state <= S_FLUSH;
          end else if (frame_n) begin
            err_frame <= 1'b1;
            bit_cnt   <= 3'd0;
            state     <= hold_vld ? S_FLUSH : S_IDLE;
          end else if (!valid_n) begin
            shift   <= {din, shift[6:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_FLUSH: begin
          hold_vld <= 1'b0;
          // A new frame may start in the flush cycle; pkt_addr stays intact
          // until the new address is complete.
          if (!frame_n) begin
            addr_sr  <= {din, addr_sr[2:1]};
            addr_cnt <= 2'd1;
            state    <= S_ADDR;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = push_req && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      busy_n  <= 1'b1;
      err_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      busy_n  <= !(count_nxt >= CNT_W'(FIFO_DEPTH - BUSY_THRESH));
      err_ovf <= push_req && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign {out_addr, out_last, out_data} = mem[rd_ptr];

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: frames are built as cycle timelines from the
// packet format, and a queue model of the FIFO tracks expected outputs.
module tb_router_port_rx;
  localparam int DEPTH  = 16;
  localparam int PAD    = 5;
  localparam int THRESH = 2;

  logic       clk = 1'b0;
  logic       reset, din, frame_n, valid_n, out_ready;
  logic       busy_n, out_valid, out_last, err_frame, err_ovf;
  logic [7:0] out_data;
  logic [3:0] out_addr;

  router_port_rx #(.FIFO_DEPTH(DEPTH), .PAD_CYCLES(PAD), .BUSY_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .busy_n(busy_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .err_frame(err_frame), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fn;
    logic        vn;
    logic        d;
    logic        pv;
    logic [12:0] pe;
    logic        ef;
  } cyc_t;

  typedef struct packed {
    int          cyc;
    logic [12:0] e;
  } vis_t;

  cyc_t        tl[$];
  logic [12:0] mq[$];
  vis_t        vis[$];
  int n_checks = 0;
  int n_fail = 0;
  int cur, ovf_seen, errf_seen;

  task automatic ensure(input int n);
    cyc_t idle;
    idle = '0;
    idle.fn = 1'b1;
    idle.vn = 1'b1;
    while (tl.size() < n) tl.push_back(idle);
  endtask

  task automatic set_stim(input int i, input logic fn, input logic vn, input logic d);
    cyc_t t;
    ensure(i + 1);
    t = tl[i]; t.fn = fn; t.vn = vn; t.d = d; tl[i] = t;
  endtask

  task automatic set_push(input int i, input logic [12:0] e);
    cyc_t t;
    ensure(i + 1);
    t = tl[i]; t.pv = 1'b1; t.pe = e; tl[i] = t;
  endtask

  task automatic set_err(input int i);
    cyc_t t;
    ensure(i + 1);
    t = tl[i]; t.ef = 1'b1; tl[i] = t;
  endtask

  // Appends one frame at cur. Bytes come LSB-first from pay; nextra random bits
  // after the last full byte make the ending abnormal; pad_abort >= 0 raises
  // frame_n in that padding cycle.
  task automatic add_frame(input logic [3:0] addr, input logic [31:0] pay, input int nbytes,
                           input int nextra, input logic [31:0] gap_mask, input int gap_pct,
                           input int pad_abort);
    int c, total;
    logic lastb, bitv;
    c = cur;
    for (int i = 0; i < 4; i++) begin
      set_stim(c, 1'b0, 1'b1, addr[i]);
      c++;
    end
    for (int p = 0; p < PAD; p++) begin
      if (p == pad_abort) begin
        set_stim(c, 1'b1, 1'b1, 1'($urandom));
        set_err(c);
        cur = c + 1;
        return;
      end
      set_stim(c, 1'b0, 1'($urandom), 1'($urandom));
      c++;
    end
    total = nbytes * 8 + nextra;
    for (int b = 0; b < total; b++) begin
      if ((b < 32 && gap_mask[b]) || int'($urandom_range(0, 99)) < gap_pct) begin
        set_stim(c, 1'b0, 1'b1, 1'($urandom));
        c++;
      end
      lastb = (b == total - 1);
      bitv  = (b < nbytes * 8) ? pay[b] : 1'($urandom);
      set_stim(c, lastb, 1'b0, bitv);
      if (b % 8 == 7 && b / 8 > 0) set_push(c, {addr, 1'b0, pay[(b/8-1)*8 +: 8]});
      if (lastb) begin
        if (nextra > 0) set_err(c);
        if (nbytes > 0) set_push(c + 1, {addr, 1'b1, pay[(nbytes-1)*8 +: 8]});
      end
      c++;
    end
    cur = c;
  endtask

  task automatic run(input int ready_pct);
    cyc_t t;
    vis_t v;
    logic pop, exp_ovf;
    logic [12:0] head;
    for (int i = 0; i < tl.size(); i++) begin
      t = tl[i];
      frame_n   = t.fn;
      valid_n   = t.vn;
      din       = t.d;
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      pop = (mq.size() > 0) && out_ready;
      if (out_valid && out_ready) begin
        v.cyc = i;
        v.e   = {out_addr, out_last, out_data};
        vis.push_back(v);
      end
      @(posedge clk); #1;
      if (pop) head = mq.pop_front();
      exp_ovf = 1'b0;
      if (t.pv) begin
        if (mq.size() < DEPTH) mq.push_back(t.pe);
        else exp_ovf = 1'b1;
      end
      if (err_ovf === 1'b1) ovf_seen++;
      if (err_frame === 1'b1) errf_seen++;
      n_checks++;
      if (out_valid !== (mq.size() > 0)) begin
        n_fail++;
        $display("FAIL out_valid cyc %0d: got %b want %b", i, out_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if ({out_addr, out_last, out_data} !== mq[0]) begin
          n_fail++;
          $display("FAIL head cyc %0d: got %h want %h", i, {out_addr, out_last, out_data}, mq[0]);
        end
      end
      n_checks++;
      if (busy_n !== !(mq.size() >= DEPTH - THRESH)) begin
        n_fail++;
        $display("FAIL busy_n cyc %0d: got %b want %b (level %0d)", i, busy_n,
                 !(mq.size() >= DEPTH - THRESH), mq.size());
      end
      n_checks++;
      if (err_ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL err_ovf cyc %0d: got %b want %b", i, err_ovf, exp_ovf);
      end
      n_checks++;
      if (err_frame !== t.ef) begin
        n_fail++;
        $display("FAIL err_frame cyc %0d: got %b want %b", i, err_frame, t.ef);
      end
    end
  endtask

  task automatic clear_run();
    tl.delete();
    vis.delete();
    cur = 0;
    ovf_seen = 0;
    errf_seen = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    clear_run();
  endtask

  task automatic check_vis(input string name, input int k, input int cyc, input logic [12:0] e);
    n_checks++;
    if (vis.size() <= k) begin
      n_fail++;
      $display("FAIL %s: byte %0d never delivered, want %h", name, k, e);
    end else if (vis[k].e !== e || (cyc >= 0 && vis[k].cyc != cyc)) begin
      n_fail++;
      $display("FAIL %s: byte %0d got %h@%0d want %h@%0d", name, k, vis[k].e, vis[k].cyc, e, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset out_valid", int'(out_valid), 0);
    check_int("reset busy_n", int'(busy_n), 1);
    check_int("reset err_frame", int'(err_frame), 0);
    check_int("reset err_ovf", int'(err_ovf), 0);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    add_frame(4'hA, 32'h0000813C, 2, 0, 32'h0, 0, -1);
    ensure(cur + 4);
    run(100);
    check_vis("basic byte0", 0, 25, {4'hA, 1'b0, 8'h3C});
    check_vis("basic byte1", 1, 26, {4'hA, 1'b1, 8'h81});
    check_int("basic count", vis.size(), 2);
    check_int("basic errors", errf_seen + ovf_seen, 0);
  endtask

  task automatic test_gapped();
    do_reset();
    add_frame(4'hA, 32'h0000813C, 2, 0, 32'h0000_0408, 0, -1);
    ensure(cur + 4);
    run(100);
    check_vis("gapped byte0", 0, 27, {4'hA, 1'b0, 8'h3C});
    check_vis("gapped byte1", 1, 28, {4'hA, 1'b1, 8'h81});
    check_int("gapped count", vis.size(), 2);
  endtask

  task automatic test_short_frame();
    do_reset();
    add_frame(4'h7, 32'h0, 0, 0, 32'h0, 0, 2);
    ensure(cur + 3);
    cur = tl.size();
    add_frame(4'h9, 32'h00000055, 1, 3, 32'h0, 0, -1);
    ensure(cur + 4);
    run(100);
    check_int("short err_frame pulses", errf_seen, 2);
    check_int("short count", vis.size(), 1);
    check_vis("short byte", 0, -1, {4'h9, 1'b1, 8'h55});
  endtask

  task automatic test_back_pressure();
    logic [12:0] expq[$];
    logic [31:0] pay;
    logic [3:0]  a;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      pay = $urandom;
      a   = 4'($urandom);
      add_frame(a, pay, (p < 4) ? 4 : 1, 0, 32'h0, 0, -1);
      if (p < 4)
        for (int k = 0; k < 4; k++) expq.push_back({a, (k == 3), pay[k*8 +: 8]});
    end
    ensure(cur + 3);
    run(0);
    check_int("bp overflow pulses", ovf_seen, 1);
    check_int("bp busy_n low", int'(busy_n), 0);
    clear_run();
    ensure(24);
    run(100);
    check_int("bp drained", vis.size(), 16);
    for (int k = 0; k < 16; k++) check_vis("bp order", k, -1, expq[k]);
    check_int("bp busy_n high", int'(busy_n), 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_frame(4'h5, 32'h0000C3A7, 2, 0, 32'h0, 0, -1);
    add_frame(4'h3, 32'h00001E96, 2, 0, 32'h0, 0, -1);
    ensure(cur + 4);
    run(100);
    check_int("b2b count", vis.size(), 4);
    check_vis("b2b old last", 1, -1, {4'h5, 1'b1, 8'hC3});
    check_vis("b2b new first", 2, -1, {4'h3, 1'b0, 8'h96});
    check_vis("b2b new last", 3, -1, {4'h3, 1'b1, 8'h1E});
  endtask

  task automatic test_reset_mid_frame();
    int cut;
    do_reset();
    add_frame(4'h6, 32'h0000BEEF, 2, 0, 32'h0, 0, -1);
    cut = cur + 9 + 12;
    add_frame(4'h2, 32'h00123456, 3, 0, 32'h0, 0, -1);
    while (tl.size() > cut) void'(tl.pop_back());
    run(0);
    reset = 1'b1; frame_n = 1'b0; valid_n = 1'b0; din = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_int("midreset out_valid", int'(out_valid), 0);
    check_int("midreset busy_n", int'(busy_n), 1);
    mq.delete();
    clear_run();
    add_frame(4'hC, 32'h00005AA5, 2, 0, 32'h0, 0, -1);
    ensure(cur + 4);
    run(100);
    check_int("midreset count", vis.size(), 2);
    check_vis("midreset byte0", 0, 25, {4'hC, 1'b0, 8'hA5});
    check_vis("midreset byte1", 1, 26, {4'hC, 1'b1, 8'h5A});
  endtask

  task automatic test_random();
    int nb, ne, pa;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(0, 4);
      ne = (nb == 0) ? $urandom_range(1, 7) : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      pa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, PAD - 1) : -1;
      add_frame(4'($urandom), $urandom, nb, ne, 32'h0, 20, pa);
      if ($urandom_range(0, 2) == 0) begin
        ensure(cur + $urandom_range(1, 4));
        cur = tl.size();
      end
    end
    ensure(cur + 60);
    run(60);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_short_frame();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
